// File: rtl/mcalu_arb.sv
// mcalu_arb: two-requester issue arbiter and single-entry holding slot in
// front of the multi-cycle ALU. The oldest op relative to the ROB head wins
// the shared issue port. Equal ages fall back to a round-robin tie bit.
// Optional build macro MCALU_ARB_PERF_EN adds three 32-bit activity counters.
module mcalu_arb #(
   parameter int XLEN    = 32,
   parameter int ROBID_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rs0_valid,
   input  logic [4:0]         rs0_op,
   input  logic [ROBID_W-1:0] rs0_robid,
   input  logic [5:0]         rs0_rd,
   input  logic [XLEN-1:0]    rs0_op1,
   input  logic [XLEN-1:0]    rs0_op2,
   output logic               arb_rs0_ack,
   input  logic               rs1_valid,
   input  logic [4:0]         rs1_op,
   input  logic [ROBID_W-1:0] rs1_robid,
   input  logic [5:0]         rs1_rd,
   input  logic [XLEN-1:0]    rs1_op1,
   input  logic [XLEN-1:0]    rs1_op2,
   output logic               arb_rs1_ack,
   input  logic [ROBID_W-1:0] rob_head,
   input  logic               rob_flush,
   output logic               arb_mcalu_issue,
   output logic [4:0]         arb_mcalu_op,
   output logic [ROBID_W-1:0] arb_mcalu_robid,
   output logic [5:0]         arb_mcalu_rd,
   output logic [XLEN-1:0]    arb_mcalu_op1,
   output logic [XLEN-1:0]    arb_mcalu_op2,
   input  logic               mcalu_stall
`ifdef MCALU_ARB_PERF_EN
   ,
   output logic [31:0]        perf_issue_cnt,
   output logic [31:0]        perf_conflict_cnt,
   output logic [31:0]        perf_block_cnt
`endif
);

   logic               slot_valid;
   logic [4:0]         slot_op;
   logic [ROBID_W-1:0] slot_robid;
   logic [5:0]         slot_rd;
   logic [XLEN-1:0]    slot_op1;
   logic [XLEN-1:0]    slot_op2;
   logic               rr;

   logic               ready;
   logic               can_grant;
   logic               both_valid;
   logic               age_tie;
   logic               pick_rs1;
   logic               grant;
   logic [ROBID_W-1:0] age0;
   logic [ROBID_W-1:0] age1;

   // Age-based selection: distance from the ROB head, modulo the id space,
   // so the comparison stays correct when ids wrap around.
   always_comb begin
      ready       = ~slot_valid | ~mcalu_stall;
      can_grant   = ready & ~rob_flush & ~rst;
      both_valid  = rs0_valid & rs1_valid;
      age0        = rs0_robid - rob_head;
      age1        = rs1_robid - rob_head;
      age_tie     = both_valid & (age0 == age1);
      pick_rs1    = 1'b0;
      if (both_valid) begin
         if (age_tie) begin
            pick_rs1 = rr;
         end else begin
            pick_rs1 = (age1 < age0);
         end
      end else begin
         pick_rs1 = rs1_valid;
      end
      arb_rs0_ack = can_grant & rs0_valid & ~pick_rs1;
      arb_rs1_ack = can_grant & rs1_valid & pick_rs1;
      grant       = arb_rs0_ack | arb_rs1_ack;
   end

   // Holding slot: loads the winner, drains when the ALU accepts, holds under
   // stall, and is emptied by a flush regardless of stall. Fields are kept
   // when the slot empties so the outputs only change on a new load.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= 1'b0;
         slot_op    <= '0;
         slot_robid <= '0;
         slot_rd    <= '0;
         slot_op1   <= '0;
         slot_op2   <= '0;
         rr         <= 1'b0;
      end else if (rob_flush) begin
         slot_valid <= 1'b0;
      end else if (ready) begin
         slot_valid <= grant;
         if (arb_rs1_ack) begin
            slot_op    <= rs1_op;
            slot_robid <= rs1_robid;
            slot_rd    <= rs1_rd;
            slot_op1   <= rs1_op1;
            slot_op2   <= rs1_op2;
         end else if (arb_rs0_ack) begin
            slot_op    <= rs0_op;
            slot_robid <= rs0_robid;
            slot_rd    <= rs0_rd;
            slot_op1   <= rs0_op1;
            slot_op2   <= rs0_op2;
         end
         if (grant & age_tie) begin
            rr <= ~rr;
         end
      end
   end

   assign arb_mcalu_issue = slot_valid;
   assign arb_mcalu_op    = slot_op;
   assign arb_mcalu_robid = slot_robid;
   assign arb_mcalu_rd    = slot_rd;
   assign arb_mcalu_op1   = slot_op1;
   assign arb_mcalu_op2   = slot_op2;

`ifdef MCALU_ARB_PERF_EN
   // Activity counters: issues, two-way conflicts resolved, and cycles a
   // requester was blocked by a full, stalled slot. Flush leaves them intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issue_cnt    <= '0;
         perf_conflict_cnt <= '0;
         perf_block_cnt    <= '0;
      end else begin
         if (slot_valid & ~mcalu_stall) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if (both_valid & grant) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
         if ((rs0_valid | rs1_valid) & ~ready) begin
            perf_block_cnt <= perf_block_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
